mem_port_arbiter: RTL and testbench

- Shares the single-port RAM between the instruction-fetch requester (read-only) and the data-access requester (load/store). This replaces the direct memGetData address mux in front of the RAM.
- Each requester uses a req/ack handshake. The arbiter grants one requester at a time, round-robin on ties.
- It holds the RAM address and direction stable for MEM_LATENCY cycles, registers the read word, and returns it with a one-cycle ack pulse.

---
 rtl/mem_port_arbiter_if.sv | 38 +++
 rtl/mem_port_arbiter.sv | 132 +++++++++++++
 tb/tb_mem_port_arbiter.sv | 218 +++++++++++++++++++++
 3 files changed

// File: rtl/mem_port_arbiter_if.sv
// Requester and RAM-side signals of the memory port arbiter, bundled as one interface.
// Latency: none, wires only.
// Backpressure: req is held until the matching one-cycle ack. The RAM side has no stall.
interface mem_port_arbiter_if #(
    parameter int ADDRESS_SIZE = 11,
    parameter int WORD_SIZE    = 64
);
    // instruction fetch requester
    logic                    i_req;
    logic [ADDRESS_SIZE-1:0] i_addr;
    logic                    i_ack;
    logic [WORD_SIZE-1:0]    i_rdata;
    // data requester
    logic                    d_req;
    logic                    d_we;
    logic [ADDRESS_SIZE-1:0] d_addr;
    logic [WORD_SIZE-1:0]    d_wdata;
    logic                    d_ack;
    logic [WORD_SIZE-1:0]    d_rdata;
    // RAM side
    logic [ADDRESS_SIZE-1:0] mem_address;
    logic                    mem_isReading;
    logic [WORD_SIZE-1:0]    mem_dataIn;
    logic [WORD_SIZE-1:0]    mem_dataOut;
    logic                    busy;

    // arbiter side
    modport slave (
        input  i_req, i_addr, d_req, d_we, d_addr, d_wdata, mem_dataOut,
        output i_ack, i_rdata, d_ack, d_rdata, mem_address, mem_isReading, mem_dataIn, busy
    );

    // requesters plus RAM, as seen from outside the arbiter
    modport master (
        output i_req, i_addr, d_req, d_we, d_addr, d_wdata, mem_dataOut,
        input  i_ack, i_rdata, d_ack, d_rdata, mem_address, mem_isReading, mem_dataIn, busy
    );
endinterface

// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter that shares one single-port RAM between instruction fetch and data access.
// Latency: request in IDLE at cycle N gives an ack at N+MEM_LATENCY+1, i.e. one access per MEM_LATENCY+2 cycles.
// Backpressure: the losing or late requester keeps req high and waits for the next IDLE cycle.
module mem_port_arbiter #(
    parameter int ADDRESS_SIZE = 11,
    parameter int WORD_SIZE    = 64,
    parameter int MEM_LATENCY  = 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    mem_port_arbiter_if.slave    bus
);
    typedef enum logic [1:0] {IDLE = 2'd0, ACCESS = 2'd1, RESP = 2'd2} state_t;

    localparam logic       OWN_INSTR = 1'b0;
    localparam logic       OWN_DATA  = 1'b1;
    localparam logic [3:0] CNT_INIT  = 4'(MEM_LATENCY - 1);

    state_t                  state_q, state_d;
    logic [3:0]              cnt_q, cnt_d;
    logic                    owner_q, owner_d;
    logic                    last_grant_q, last_grant_d;
    logic [ADDRESS_SIZE-1:0] addr_q, addr_d;
    logic                    we_q, we_d;
    logic [WORD_SIZE-1:0]    wdata_q, wdata_d;
    logic [WORD_SIZE-1:0]    i_rdata_q, i_rdata_d;
    logic [WORD_SIZE-1:0]    d_rdata_q, d_rdata_d;

    logic                    pick_data;
    logic                    is_store;

    // Data wins when it is the only requester, or on a tie when instruction fetch went last.
    assign pick_data = bus.d_req && (!bus.i_req || (last_grant_q == OWN_INSTR));
    assign is_store  = (owner_q == OWN_DATA) && we_q;

    // State register plus latched request and result registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            cnt_q        <= 4'd0;
            owner_q      <= OWN_INSTR;
            last_grant_q <= OWN_DATA;
            addr_q       <= '0;
            we_q         <= 1'b0;
            wdata_q      <= '0;
            i_rdata_q    <= '0;
            d_rdata_q    <= '0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            owner_q      <= owner_d;
            last_grant_q <= last_grant_d;
            addr_q       <= addr_d;
            we_q         <= we_d;
            wdata_q      <= wdata_d;
            i_rdata_q    <= i_rdata_d;
            d_rdata_q    <= d_rdata_d;
        end
    end

    // Next state: grant in IDLE, count down the hold time in ACCESS, capture the result on leaving ACCESS.
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        owner_d      = owner_q;
        last_grant_d = last_grant_q;
        addr_d       = addr_q;
        we_d         = we_q;
        wdata_d      = wdata_q;
        i_rdata_d    = i_rdata_q;
        d_rdata_d    = d_rdata_q;
        unique case (state_q)
            IDLE: begin
                if (bus.i_req || bus.d_req) begin
                    state_d      = ACCESS;
                    cnt_d        = CNT_INIT;
                    owner_d      = pick_data ? OWN_DATA : OWN_INSTR;
                    last_grant_d = pick_data ? OWN_DATA : OWN_INSTR;
                    addr_d       = pick_data ? bus.d_addr : bus.i_addr;
                    we_d         = pick_data && bus.d_we;
                    wdata_d      = pick_data ? bus.d_wdata : '0;
                end
            end
            ACCESS: begin
                if (cnt_q != 4'd0) begin
                    cnt_d = cnt_q - 4'd1;
                end else begin
                    state_d = RESP;
                    if (owner_q == OWN_DATA) begin
                        d_rdata_d = is_store ? '0 : bus.mem_dataOut;
                    end else begin
                        i_rdata_d = bus.mem_dataOut;
                    end
                end
            end
            RESP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Outputs decoded from state, so a reset drops a pending write strobe without waiting for a clock.
    always_comb begin
        bus.i_ack         = 1'b0;
        bus.d_ack         = 1'b0;
        bus.mem_address   = '0;
        bus.mem_isReading = 1'b1;
        bus.mem_dataIn    = '0;
        bus.busy          = 1'b0;
        unique case (state_q)
            ACCESS: begin
                bus.mem_address   = addr_q;
                bus.mem_dataIn    = wdata_q;
                bus.mem_isReading = !is_store;
                bus.busy          = 1'b1;
            end
            RESP: begin
                bus.i_ack = (owner_q == OWN_INSTR);
                bus.d_ack = (owner_q == OWN_DATA);
                bus.busy  = 1'b1;
            end
            default: begin
            end
        endcase
    end

    assign bus.i_rdata = i_rdata_q;
    assign bus.d_rdata = d_rdata_q;
endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: two instances (MEM_LATENCY 1 and 4), each with its own RAM model.
// Latency: inputs are driven and outputs sampled on the falling edge.
// Backpressure: requesters follow the req-held-until-ack handshake.
module tb_mem_port_arbiter;
    localparam int AW = 11;
    localparam int DW = 64;

    logic clk;
    logic rst_n;
    int   n_chk;
    int   n_fail;

    mem_port_arbiter_if #(.ADDRESS_SIZE(AW), .WORD_SIZE(DW)) bus  ();
    mem_port_arbiter_if #(.ADDRESS_SIZE(AW), .WORD_SIZE(DW)) bus4 ();

    mem_port_arbiter #(.ADDRESS_SIZE(AW), .WORD_SIZE(DW), .MEM_LATENCY(1)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    mem_port_arbiter #(.ADDRESS_SIZE(AW), .WORD_SIZE(DW), .MEM_LATENCY(4)) dut4 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus4)
    );

    // RAM models: combinational read, write on the rising edge while isReading is low
    logic [DW-1:0] ram0 [0:(1<<AW)-1];
    logic [DW-1:0] ram4 [0:(1<<AW)-1];
    logic          ld0_en;
    logic          ld4_en;
    logic [AW-1:0] ld_a;
    logic [DW-1:0] ld_d;

    assign bus.mem_dataOut  = ram0[bus.mem_address];
    assign bus4.mem_dataOut = ram4[bus4.mem_address];

    always @(posedge clk) begin
        if (ld0_en) ram0[ld_a] <= ld_d;
        else if (!bus.mem_isReading) ram0[bus.mem_address] <= bus.mem_dataIn;
        if (ld4_en) ram4[ld_a] <= ld_d;
        else if (!bus4.mem_isReading) ram4[bus4.mem_address] <= bus4.mem_dataIn;
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk = n_chk + 1;
        if (got !== exp) begin
            n_fail = n_fail + 1;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic preload(input bit sel4, input logic [AW-1:0] a, input logic [DW-1:0] d);
        ld_a = a;
        ld_d = d;
        if (sel4) ld4_en = 1'b1; else ld0_en = 1'b1;
        tick();
        ld0_en = 1'b0;
        ld4_en = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        n_chk  = 0;
        n_fail = 0;
        rst_n  = 1'b0;
        ld0_en = 1'b0;
        ld4_en = 1'b0;
        ld_a   = '0;
        ld_d   = '0;
        bus.i_req   = 1'b0;  bus.i_addr  = '0;
        bus.d_req   = 1'b0;  bus.d_we    = 1'b0;
        bus.d_addr  = '0;    bus.d_wdata = '0;
        bus4.i_req  = 1'b0;  bus4.i_addr = '0;
        bus4.d_req  = 1'b0;  bus4.d_we   = 1'b0;
        bus4.d_addr = '0;    bus4.d_wdata = '0;

        tick();
        preload(1'b0, 11'h004, 64'h0000_0000_0ABC_DEF0);
        preload(1'b0, 11'h010, 64'h0000_0000_0000_DEAD);
        preload(1'b0, 11'h030, 64'h5555_5555_5555_5555);
        preload(1'b1, 11'h020, 64'h0000_0000_CAFE_F00D);

        // reset state
        chk_eq("rst_i_ack",   64'(bus.i_ack), 64'd0);
        chk_eq("rst_d_ack",   64'(bus.d_ack), 64'd0);
        chk_eq("rst_i_rdata", bus.i_rdata, 64'd0);
        chk_eq("rst_d_rdata", bus.d_rdata, 64'd0);
        chk_eq("rst_addr",    64'(bus.mem_address), 64'd0);
        chk_eq("rst_isrd",    64'(bus.mem_isReading), 64'd1);
        chk_eq("rst_din",     bus.mem_dataIn, 64'd0);
        chk_eq("rst_busy",    64'(bus.busy), 64'd0);
        rst_n = 1'b1;
        tick();

        // single instruction fetch, 3-cycle round trip
        bus.i_req = 1'b1; bus.i_addr = 11'h004;
        tick();
        chk_eq("if_addr",  64'(bus.mem_address), 64'h004);
        chk_eq("if_busy",  64'(bus.busy), 64'd1);
        chk_eq("if_isrd",  64'(bus.mem_isReading), 64'd1);
        chk_eq("if_noack", 64'(bus.i_ack), 64'd0);
        tick();
        chk_eq("if_ack",   64'(bus.i_ack), 64'd1);
        chk_eq("if_dack",  64'(bus.d_ack), 64'd0);
        chk_eq("if_rdata", bus.i_rdata, 64'h0000_0000_0ABC_DEF0);
        bus.i_req = 1'b0;
        tick();
        chk_eq("if_ack_off",  64'(bus.i_ack), 64'd0);
        chk_eq("if_idle",     64'(bus.busy), 64'd0);
        chk_eq("if_rdata_hd", bus.i_rdata, 64'h0000_0000_0ABC_DEF0);

        // store then load back
        bus.d_req = 1'b1; bus.d_we = 1'b1; bus.d_addr = 11'h010; bus.d_wdata = 64'h1122_3344_5566_7788;
        tick();
        chk_eq("st_isrd", 64'(bus.mem_isReading), 64'd0);
        chk_eq("st_addr", 64'(bus.mem_address), 64'h010);
        chk_eq("st_din",  bus.mem_dataIn, 64'h1122_3344_5566_7788);
        tick();
        chk_eq("st_isrd_resp", 64'(bus.mem_isReading), 64'd1);
        chk_eq("st_ack",       64'(bus.d_ack), 64'd1);
        chk_eq("st_rdata",     bus.d_rdata, 64'd0);
        bus.d_req = 1'b0;
        tick();
        bus.d_req = 1'b1; bus.d_we = 1'b0;
        tick();
        chk_eq("ld_isrd", 64'(bus.mem_isReading), 64'd1);
        tick();
        chk_eq("ld_ack",   64'(bus.d_ack), 64'd1);
        chk_eq("ld_rdata", bus.d_rdata, 64'h1122_3344_5566_7788);
        bus.d_req = 1'b0;
        tick();

        // tie held continuously: grants alternate INSTR, DATA, INSTR, DATA
        bus.i_req = 1'b1; bus.i_addr = 11'h004;
        bus.d_req = 1'b1; bus.d_we = 1'b0; bus.d_addr = 11'h010;
        for (int c = 1; c <= 11; c++) begin
            tick();
            chk_eq($sformatf("rr_iack_c%0d", c), 64'(bus.i_ack), 64'((c == 2) || (c == 8)));
            chk_eq($sformatf("rr_dack_c%0d", c), 64'(bus.d_ack), 64'((c == 5) || (c == 11)));
            if (c == 11) begin
                bus.i_req = 1'b0;
                bus.d_req = 1'b0;
            end
        end
        tick();
        chk_eq("rr_idle", 64'(bus.busy), 64'd0);

        // reset in the middle of a store: write strobe drops at once, no ack, RAM untouched
        bus.d_req = 1'b1; bus.d_we = 1'b1; bus.d_addr = 11'h030; bus.d_wdata = 64'hFFFF_0000_FFFF_0000;
        tick();
        chk_eq("ab_isrd_pre", 64'(bus.mem_isReading), 64'd0);
        #2;
        rst_n = 1'b0;
        bus.d_req = 1'b0;
        #1;
        chk_eq("ab_isrd", 64'(bus.mem_isReading), 64'd1);
        chk_eq("ab_busy", 64'(bus.busy), 64'd0);
        tick();
        chk_eq("ab_noack", 64'(bus.d_ack), 64'd0);
        rst_n = 1'b1;
        tick();
        chk_eq("ab_noack2", 64'(bus.d_ack), 64'd0);
        bus.d_req = 1'b1; bus.d_we = 1'b0; bus.d_addr = 11'h030;
        tick();
        tick();
        chk_eq("ab_ld_ack",   64'(bus.d_ack), 64'd1);
        chk_eq("ab_ld_rdata", bus.d_rdata, 64'h5555_5555_5555_5555);
        bus.d_req = 1'b0;
        tick();

        // req held through ack: regranted in the next IDLE cycle
        bus.d_req = 1'b1; bus.d_we = 1'b0; bus.d_addr = 11'h004;
        tick();
        tick();
        chk_eq("hd_ack1",   64'(bus.d_ack), 64'd1);
        chk_eq("hd_rdata1", bus.d_rdata, 64'h0000_0000_0ABC_DEF0);
        tick();
        chk_eq("hd_idle_ack",  64'(bus.d_ack), 64'd0);
        chk_eq("hd_idle_busy", 64'(bus.busy), 64'd0);
        tick();
        chk_eq("hd_acc_busy", 64'(bus.busy), 64'd1);
        chk_eq("hd_acc_ack",  64'(bus.d_ack), 64'd0);
        tick();
        chk_eq("hd_ack2", 64'(bus.d_ack), 64'd1);
        bus.d_req = 1'b0;
        tick();

        // MEM_LATENCY = 4: address held 4 cycles, ack at cycle 5
        bus4.d_req = 1'b1; bus4.d_we = 1'b0; bus4.d_addr = 11'h020;
        for (int c = 1; c <= 6; c++) begin
            tick();
            chk_eq($sformatf("l4_addr_c%0d", c), 64'(bus4.mem_address), (c <= 4) ? 64'h020 : 64'h000);
            chk_eq($sformatf("l4_busy_c%0d", c), 64'(bus4.busy), 64'(c <= 5));
            chk_eq($sformatf("l4_ack_c%0d", c),  64'(bus4.d_ack), 64'(c == 5));
            if (c == 5) begin
                chk_eq("l4_rdata", bus4.d_rdata, 64'h0000_0000_CAFE_F00D);
                bus4.d_req = 1'b0;
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
